// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus bundle for instr_fetch_unit: instruction-memory address/data,
// redirect request, and the decode-facing valid/ready instruction stream.
// "master" is the fetch unit's view; "slave" is the memory/decode/branch side.
interface instr_fetch_unit_if #(
  parameter int unsigned FIFO_DEPTH = 2
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   PC_new;
  logic [31:0]   Instr;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr_out;
  logic [31:0]   instr_pc;
  logic [CW-1:0] fifo_count;
  logic          halted;

  modport master (
    output PC_new,
    input  Instr,
    input  redirect_valid,
    input  redirect_pc,
    output instr_valid,
    input  instr_ready,
    output instr_out,
    output instr_pc,
    output fifo_count,
    output halted
  );

  modport slave (
    input  PC_new,
    output Instr,
    output redirect_valid,
    output redirect_pc,
    input  instr_valid,
    output instr_ready,
    input  instr_out,
    input  instr_pc,
    input  fifo_count,
    input  halted
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: drives a word-indexed PC to a combinational instruction
// memory, captures {PC, Instr} into a small prefetch FIFO and hands the FIFO
// head to decode over valid/ready. Redirects flush the FIFO and reload the PC.
// Optional feature macro: FETCH_HALT_EN -- stop fetching after HALT_WORD is
// pushed; without it, halted is constant 0 and fetching never stops.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] HALT_WORD  = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  instr_fetch_unit_if.master      bus
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic [31:0]   pc_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [31:0]   head_instr_q, head_pc_q;
  logic          halted_q;

  logic [31:0]   st_instr [FIFO_DEPTH];
  logic [31:0]   st_pc    [FIFO_DEPTH];

  logic          pop;
  logic          fetch_en;
  logic [PW-1:0] rd_ptr_n, wr_ptr_n;
  logic [CW-1:0] count_n;
  logic [CW-1:0] left_after_pop;
  logic          head_load;
  logic [31:0]   head_instr_n, head_pc_n;
  logic          halt_hit;

  assign pop      = (count_q != '0) && bus.instr_ready;
  assign fetch_en = !bus.redirect_valid && !halted_q && ((count_q < DEPTH_C) || pop);
  assign halt_hit = HALT_EN && fetch_en && (bus.Instr == HALT_WORD);

  // Next FIFO pointers/count and the value the head register will present.
  // The head is a register rather than a read of storage so that an empty
  // FIFO keeps showing the last delivered instruction. When the entry being
  // pushed becomes the head, it is taken straight from the memory bus.
  always_comb begin
    rd_ptr_n       = rd_ptr_q;
    wr_ptr_n       = wr_ptr_q;
    count_n        = count_q;
    left_after_pop = count_q - CW'(pop);
    head_load      = 1'b0;
    head_instr_n   = head_instr_q;
    head_pc_n      = head_pc_q;
    if (bus.redirect_valid) begin
      rd_ptr_n = '0;
      wr_ptr_n = '0;
      count_n  = '0;
    end else begin
      rd_ptr_n = rd_ptr_q + PW'(pop);
      wr_ptr_n = wr_ptr_q + PW'(fetch_en);
      count_n  = left_after_pop + CW'(fetch_en);
      if (left_after_pop != '0) begin
        head_load    = 1'b1;
        head_instr_n = st_instr[rd_ptr_n];
        head_pc_n    = st_pc[rd_ptr_n];
      end else if (fetch_en) begin
        head_load    = 1'b1;
        head_instr_n = bus.Instr;
        head_pc_n    = pc_q;
      end
    end
  end

  // Control state: PC, pointers, occupancy, head registers, halt flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_instr_q <= '0;
      head_pc_q    <= '0;
      halted_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_n;
      rd_ptr_q <= rd_ptr_n;
      count_q  <= count_n;
      if (bus.redirect_valid) begin
        pc_q     <= bus.redirect_pc;
        halted_q <= 1'b0;
      end else begin
        if (fetch_en) pc_q <= pc_q + 32'd1;
        if (halt_hit) halted_q <= 1'b1;
      end
      if (head_load) begin
        head_instr_q <= head_instr_n;
        head_pc_q    <= head_pc_n;
      end
    end
  end

  // FIFO storage: written at the tail on every fetch; contents are don't-care
  // until written, so no reset is needed.
  always_ff @(posedge clk) begin
    if (fetch_en) begin
      st_instr[wr_ptr_q] <= bus.Instr;
      st_pc[wr_ptr_q]    <= pc_q;
    end
  end

  assign bus.PC_new      = pc_q;
  assign bus.instr_valid = (count_q != '0);
  assign bus.instr_out   = head_instr_q;
  assign bus.instr_pc    = head_pc_q;
  assign bus.fifo_count  = count_q;
  assign bus.halted      = halted_q;

endmodule
